// File: rtl/systolic_row_loader.sv
// rtl/systolic_row_loader.sv - captures a DEPTH-element row from a stream and feeds it to the array edge
// Define ROW_SKEW_EN for a diagonal one-lane-per-cycle feed; otherwise all lanes are fed in one cycle.
module systolic_row_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                start,
    output logic                                full,
    output logic                                busy,
    output logic                                done,
    output logic [CNT_W-1:0]                    load_count,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]    out_data,
    output logic [DEPTH-1:0]                    out_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FULL,
        ST_FEED
    } state_t;

    state_t                             state;
    state_t                             state_next;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]   bank;
    logic [PTR_W-1:0]                   wptr;
    logic [CNT_W-1:0]                   count;
    logic                               accept;
    logic                               last_write;
    logic                               feed_last;

    assign accept     = (state == ST_LOAD) && in_valid;
    assign last_write = accept && (wptr == PTR_W'(DEPTH - 1));

`ifdef ROW_SKEW_EN
    logic [PTR_W-1:0] feed_cnt;

    assign feed_last = (feed_cnt == PTR_W'(DEPTH - 1));

    // Counter is cleared when the feed ends so the next row starts from lane 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            feed_cnt <= '0;
        end else if (state == ST_FULL && start) begin
            feed_cnt <= '0;
        end else if (state == ST_FEED) begin
            feed_cnt <= feed_last ? '0 : feed_cnt + PTR_W'(1);
        end
    end
`else
    assign feed_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: if (last_write) state_next = ST_FULL;
            ST_FULL: if (start)      state_next = ST_FEED;
            ST_FEED: if (feed_last)  state_next = ST_LOAD;
            default:                 state_next = ST_LOAD;
        endcase
    end

    // The bank is not cleared between rows; only reset zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bank  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                bank[wptr] <= in_data;
                wptr       <= last_write ? '0 : wptr + PTR_W'(1);
                count      <= count + CNT_W'(1);
            end
            if (state == ST_FEED && feed_last) begin
                count <= '0;
            end
        end
    end

    always_comb begin
        in_ready = (state == ST_LOAD);
        full     = (state == ST_FULL);
        busy     = (state == ST_FEED);
        done     = busy && feed_last;
`ifdef ROW_SKEW_EN
        out_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out_valid[i] = busy && (feed_cnt == PTR_W'(i));
        end
`else
        out_valid = {DEPTH{busy}};
`endif
    end

    assign load_count = count;
    assign out_data   = bank;

endmodule

// File: tb/tb_systolic_row_loader.sv
// tb/tb_systolic_row_loader.sv - scoreboard bench for systolic_row_loader (follows ROW_SKEW_EN if defined)
module tb_systolic_row_loader;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef ROW_SKEW_EN
    localparam int FEED_LEN = DEPTH;
`else
    localparam int FEED_LEN = 1;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              in_data;
    logic                       start;
    logic                       full;
    logic                       busy;
    logic                       done;
    logic [CW-1:0]              load_count;
    logic [DEPTH-1:0][DW-1:0]   out_data;
    logic [DEPTH-1:0]           out_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0]    exp_lane[$];
    logic [DEPTH-1:0] exp_valid[$];
    logic [DW-1:0]    prev_row[DEPTH];

    systolic_row_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .start      (start),
        .full       (full),
        .busy       (busy),
        .done       (done),
        .load_count (load_count),
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bank_from_queue(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] e;
            if (exp_lane.size() == 0) begin
                check({tag, "_underflow"}, 64'(i), 64'(DEPTH));
                return;
            end
            e = exp_lane.pop_front();
            prev_row[i] = e;
            check($sformatf("%s_lane%0d", tag, i), 64'(out_data[i]), 64'(e));
        end
    endtask

    task automatic push_feed_expect();
        for (int k = 0; k < FEED_LEN; k++) begin
            if (FEED_LEN == 1) exp_valid.push_back({DEPTH{1'b1}});
            else               exp_valid.push_back(DEPTH'(1) << k);
        end
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;

        // reset held for three cycles
        repeat (3) tick();
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_load_count", 64'(load_count), 64'h0);
        reset = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_flags", {61'h0, full, busy, done}, 64'h0);

        // continuous stream 0x11..0x88
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'h11 * (i + 1));
            exp_lane.push_back(in_data);
            tick();
            check($sformatf("cont_count%0d", i), 64'(load_count), 64'(i + 1));
            check($sformatf("cont_full%0d", i), 64'(full), 64'(i == DEPTH - 1));
        end
        check("cont_in_ready", 64'(in_ready), 64'h0);
        check_bank_from_queue("cont");

        // in_valid stays high through FULL and FEED with a different value
        in_data = 8'hEE;
        tick();
        check("full_hold", 64'(full), 64'h1);
        check("full_hold_count", 64'(load_count), 64'(DEPTH));
        start = 1'b1;
        push_feed_expect();
        tick();
        start = 1'b0;
        for (int k = 0; k < FEED_LEN; k++) begin
            logic [DEPTH-1:0] ev;
            ev = exp_valid.pop_front();
            check($sformatf("feed_valid%0d", k), 64'(out_valid), 64'(ev));
            check($sformatf("feed_done%0d", k), 64'(done), 64'(k == FEED_LEN - 1));
            check($sformatf("feed_busy%0d", k), 64'(busy), 64'h1);
            check($sformatf("feed_ready%0d", k), 64'(in_ready), 64'h0);
            if (k == FEED_LEN - 1) in_valid = 1'b0;
            tick();
        end
        check("post_feed_ready", 64'(in_ready), 64'h1);
        check("post_feed_busy", 64'(busy | done), 64'h0);
        check("post_feed_count", 64'(load_count), 64'h0);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("kept_lane%0d", i), 64'(out_data[i]), 64'(prev_row[i]));

        // toggling valid; start in LOAD must be ignored
        for (int h = 0; h < DEPTH; h++) begin
            in_valid = 1'b1;
            in_data  = DW'(8'hA0 + h);
            exp_lane.push_back(in_data);
            tick();
            check($sformatf("tog_count%0d", h), 64'(load_count), 64'(h + 1));
            check($sformatf("tog_full%0d", h), 64'(full), 64'(h == DEPTH - 1));
            if (h == 2)
                check("tog_old_lane3", 64'(out_data[3]), 64'(prev_row[3]));
            if (h < DEPTH - 1) begin
                in_valid = 1'b0;
                start    = (h == 1);
                tick();
                start = 1'b0;
                check($sformatf("tog_idle%0d", h), 64'(load_count), 64'(h + 1));
                check($sformatf("tog_nobusy%0d", h), 64'(busy), 64'h0);
            end
        end
        in_valid = 1'b0;
        check_bank_from_queue("tog");

        // reset in mid-FEED
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FEED_LEN > 3 ? 3 : 0) tick();
        check("abort_busy", 64'(busy), 64'h1);
        if (FEED_LEN > 3) check("abort_valid", 64'(out_valid), 64'h08);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_done", 64'(done), 64'h0);
        check("abort_busy_low", 64'(busy), 64'h0);
        check("abort_ready", 64'(in_ready), 64'h1);
        check("abort_bank", 64'(out_data), 64'h0);
        check("abort_count", 64'(load_count), 64'h0);

        // start in LOAD after the abort
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load_start_busy", 64'(busy), 64'h0);
        check("load_start_valid", 64'(out_valid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/systolic_row_loader.md
# systolic_row_loader

Parametrised successor to the fixed 8-byte operand holder in the systolic matrix datapath. Captures one matrix row or column of `DEPTH` elements from a valid/ready stream into an internal register bank. On a `start` command it feeds the row to the systolic array's edge PEs, either diagonally skewed (one lane per cycle) or all lanes at once. Sits between the operand ROM/stream source and the array's row or column inputs; one instance per array edge.

## Interface
- `DATA_WIDTH`, 8, bits per matrix element.
- `DEPTH`, 8, number of elements per row (array edge length); DEPTH ≥ 2.
- `CNT_W`, $clog2(DEPTH+1), width of `load_count`.
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  source has an element on `in_data`.
- `in_ready`  output  1  loader accepts an element this cycle.
- `in_data`  input  DATA_WIDTH  element; stored in arrival order, lane 0 first.
- `start`  input  1  single-cycle request to feed the stored row.
- `full`  output  1  all DEPTH lanes loaded and waiting for `start`.
- `busy`  output  1  feed in progress.
- `done`  output  1  one-cycle pulse in the final feed cycle.
- `load_count`  output  CNT_W  number of elements loaded into the current row.
- `out_data`  output  [DEPTH-1:0][DATA_WIDTH-1:0]  register bank contents, lane i = element i.
- `out_valid`  output  DEPTH  per-lane strobe to the array edge.

## Operation
- States:
  - LOAD (reset state)
  - FULL
  - FEED
- Reset (`reset`=0 at a clock edge, in any state):
  - State → LOAD.
  - Bank lanes, write pointer, `load_count` and feed counter cleared to 0.
  - All outputs low/zero; `in_ready`=1 from the first cycle after reset.
  - Reset during LOAD or FEED aborts the row; no `done` is produced.
- LOAD:
  - `in_ready`=1.
  - On `in_valid && in_ready`: lane[wptr] ← `in_data`; wptr and `load_count` increment.
  - When the handshake writes lane DEPTH-1: go to FULL; wptr → 0; `load_count` = DEPTH.
  - `start` is ignored in LOAD.
- FULL:
  - `in_ready`=0, `full`=1; the bank is held.
  - `start`=1 → FEED; feed counter → 0.
- FEED:
  - `busy`=1, `in_ready`=0; `start` and `in_valid` are ignored.
  - `out_valid` timing depends on the skew configuration (see Configuration).
  - On the last feed cycle: `done`=1. Next state is LOAD with `load_count`=0, wptr=0.
- `out_data` always shows the bank. Lanes keep the previous row's values until each is overwritten; the bank is not cleared on return to LOAD.
- No arithmetic on data. Counters saturate by state transition, never by wrap-around. wptr never exceeds DEPTH-1.

## Timing
- `in_ready`, `full`, `busy`, `done`, `out_valid`: decoded combinationally from registered state and counters. No combinational path from any input to any output.
- Write latency: an element accepted at edge N appears on `out_data` lane and `load_count` after edge N.
- Handshake on the last element at edge N: `full`=1 and `in_ready`=0 in cycle N+1.
- `start` sampled at edge M while in FULL: first FEED cycle is M+1.
- Return to LOAD: the cycle after the `done` cycle. `in_ready`=1 that cycle, so a new element can be accepted immediately.
- Back-to-back rows: minimum period is DEPTH (load) + 1 (start) + feed length cycles.
- `in_valid` may stay high through FULL and FEED; nothing is written and no element is lost.

## Configuration
- `ROW_SKEW_EN` defined:
  - FEED lasts DEPTH cycles, feed counter 0..DEPTH-1.
  - `out_valid` = one-hot, bit[cnt] set, giving the diagonal wavefront for the systolic array.
  - `done` is asserted with cnt = DEPTH-1.
- `ROW_SKEW_EN` not defined:
  - FEED lasts exactly 1 cycle.
  - `out_valid` = all ones during that cycle; `done` is asserted in the same cycle.
  - Feed counter logic is removed.

## Test plan
- Reset, then hold `reset`=0 for 3 cycles → `out_data` all zero, `out_valid`=0, `load_count`=0, `in_ready`=1 after release.
- DEPTH=8, stream 0x11..0x88 with `in_valid` constantly high → `full`=1 the cycle after 0x88 is accepted; lane i = 0x11·(i+1); `in_ready`=0.
- Stream with `in_valid` toggling every other cycle → `load_count` increments only on handshakes; `full` after exactly 8 handshakes.
- Skew on: `start` in FULL → `out_valid` = 0x01, 0x02, …, 0x80 on 8 consecutive cycles. `done` is high with 0x80. LOAD is entered the next cycle.
- Skew off: `start` in FULL → one cycle with `out_valid`=0xFF and `done`=1, then LOAD.
- Reset asserted in mid-FEED at cnt=3 → no `done`; next cycle state is LOAD with bank zeroed. `start` in LOAD → ignored, `busy` stays 0.
